// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: fetch-stage bus between the pipeline control, instruction memory and decode
//   slave  : the fetch stage (consumes control and imem data, produces imem address and IF/ID)
//   master : the surrounding pipeline (drives control and imem data, observes IF/ID)
interface if_fetch_stage_if;
  logic [31:0] start_pc;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_count;
  logic        misalign_err;
  modport master (
    output start_pc, stall, redirect, redirect_pc, imem_data,
    input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count, misalign_err
  );
  modport slave (
    input  start_pc, stall, redirect, redirect_pc, imem_data,
    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count, misalign_err
  );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction fetch with PC register and IF/ID pipeline register
//   clk, rst (async, active-high)
//   bus.start_pc / stall / redirect / redirect_pc / imem_data : inputs
//   bus.imem_addr (= PC), bus.ifid_instr / ifid_pc_plus4 / ifid_valid, bus.fetch_count,
//   bus.misalign_err (sticky) : outputs
module if_fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          PC_STEP   = 4
) (
  input logic            clk,
  input logic            rst,
  if_fetch_stage_if.slave bus
);
  typedef enum logic {LOAD, RUN} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, cnt_q, cnt_d, pc_next;
  logic        valid_q, valid_d, err_q, err_d;
  assign pc_next = pc_q + 32'(PC_STEP);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  // Priority in RUN: redirect flushes even when stalled; imem data is sampled only on advance.
  always_comb begin
    state_d = RUN;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (state_q == LOAD) begin
      pc_d  = {bus.start_pc[31:2], 2'b00};
      err_d = err_q | (|bus.start_pc[1:0]);
    end else if (bus.redirect) begin
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      err_d   = err_q | (|bus.redirect_pc[1:0]);
    end else if (!bus.stall) begin
      pc_d    = pc_next;
      instr_d = bus.imem_data;
      pc4_d   = pc_next;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
    end
  end
  assign bus.imem_addr     = pc_q;
  assign bus.ifid_instr    = instr_q;
  assign bus.ifid_pc_plus4 = pc4_q;
  assign bus.ifid_valid    = valid_q;
  assign bus.fetch_count   = cnt_q;
  assign bus.misalign_err  = err_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: scoreboard bench for the fetch stage
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  if_fetch_stage_if bus ();
  if_fetch_stage #(.NOP_INSTR(NOP), .PC_STEP(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a == 32'h60) ? 32'hAAAA_0001 : {~a[15:0], a[15:0]};
  endfunction
  assign bus.imem_data = imem(bus.imem_addr);
  int checks = 0;
  int errors = 0;
  exp_t        sb[$];
  logic [31:0] m_pc, m_cnt, m_instr, m_pc4;
  logic        m_valid, m_err, m_loaded;
  task automatic model_clear();
    m_pc = '0; m_cnt = '0; m_instr = NOP; m_pc4 = '0;
    m_valid = 1'b0; m_err = 1'b0; m_loaded = 1'b0;
    sb.delete();
  endtask
  task automatic do_reset(input logic [31:0] spc);
    bus.start_pc = spc;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    rst = 1'b1;
    #1;
    model_clear();
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", bus.imem_addr); end
    checks++; if (bus.ifid_instr !== NOP) begin errors++; $display("FAIL rst_instr got %h want %h", bus.ifid_instr, NOP); end
    checks++; if (bus.ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h want 0", bus.ifid_pc_plus4); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.ifid_valid); end
    checks++; if (bus.fetch_count !== 32'h0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.fetch_count); end
    checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus.misalign_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  // Drives one cycle of control, updates the model, and compares after the edge.
  task automatic cycle(input logic s, input logic r, input logic [31:0] rpc);
    exp_t e;
    logic adv;
    adv = 1'b0;
    bus.stall = s;
    bus.redirect = r;
    bus.redirect_pc = rpc;
    if (!m_loaded) begin
      m_pc = {bus.start_pc[31:2], 2'b00};
      m_err = m_err | (|bus.start_pc[1:0]);
      m_loaded = 1'b1;
    end else if (r) begin
      m_pc = {rpc[31:2], 2'b00};
      m_err = m_err | (|rpc[1:0]);
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (!s) begin
      sb.push_back('{instr: imem(m_pc), pc4: m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
      m_valid = 1'b1;
      adv = 1'b1;
    end
    @(posedge clk);
    #1;
    if (adv && sb.size() > 0) begin
      e = sb.pop_front();
      m_instr = e.instr;
      m_pc4 = e.pc4;
    end
    checks++; if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL pc got %h want %h", bus.imem_addr, m_pc); end
    checks++; if (bus.ifid_valid !== m_valid) begin errors++; $display("FAIL valid got %b want %b", bus.ifid_valid, m_valid); end
    checks++; if (bus.ifid_instr !== m_instr) begin errors++; $display("FAIL instr got %h want %h", bus.ifid_instr, m_instr); end
    checks++; if (bus.ifid_pc_plus4 !== m_pc4) begin errors++; $display("FAIL pc4 got %h want %h", bus.ifid_pc_plus4, m_pc4); end
    checks++; if (bus.fetch_count !== m_cnt) begin errors++; $display("FAIL count got %0d want %0d", bus.fetch_count, m_cnt); end
    checks++; if (bus.misalign_err !== m_err) begin errors++; $display("FAIL err got %b want %b", bus.misalign_err, m_err); end
  endtask
  task automatic test_reset_and_first_fetch();
    do_reset(32'h60);
    cycle(1'b0, 1'b0, '0);
    checks++; if (bus.imem_addr !== 32'h60) begin errors++; $display("FAIL load_pc got %h want 60", bus.imem_addr); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL load_valid got %b want 0", bus.ifid_valid); end
    cycle(1'b0, 1'b0, '0);
    checks++; if (bus.ifid_instr !== 32'hAAAA_0001) begin errors++; $display("FAIL first_instr got %h want AAAA0001", bus.ifid_instr); end
    checks++; if (bus.ifid_pc_plus4 !== 32'h64) begin errors++; $display("FAIL first_pc4 got %h want 64", bus.ifid_pc_plus4); end
    checks++; if (bus.fetch_count !== 32'd1) begin errors++; $display("FAIL first_count got %0d want 1", bus.fetch_count); end
  endtask
  task automatic test_stall();
    cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
    checks++; if (bus.imem_addr !== 32'h68) begin errors++; $display("FAIL stall_pc got %h want 68", bus.imem_addr); end
    checks++; if (bus.fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count got %0d want 2", bus.fetch_count); end
    cycle(1'b0, 1'b0, '0);
    checks++; if (bus.ifid_pc_plus4 !== 32'h6C) begin errors++; $display("FAIL resume_pc4 got %h want 6c", bus.ifid_pc_plus4); end
  endtask
  task automatic test_redirect();
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'hA0);
    checks++; if (bus.imem_addr !== 32'hA0) begin errors++; $display("FAIL redir_pc got %h want a0", bus.imem_addr); end
    checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== NOP) begin errors++; $display("FAIL redir_bubble got %b/%h want 0/%h", bus.ifid_valid, bus.ifid_instr, NOP); end
    cycle(1'b0, 1'b0, '0);
    checks++; if (bus.ifid_instr !== imem(32'hA0) || bus.ifid_pc_plus4 !== 32'hA4) begin errors++; $display("FAIL redir_target got %h/%h want %h/a4", bus.ifid_instr, bus.ifid_pc_plus4, imem(32'hA0)); end
  endtask
  task automatic test_redirect_over_stall();
    cycle(1'b1, 1'b1, 32'h102);
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL misalign_pc got %h want 100", bus.imem_addr); end
    checks++; if (bus.misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_err got %b want 1", bus.misalign_err); end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    checks++; if (bus.misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_sticky got %b want 1", bus.misalign_err); end
  endtask
  task automatic test_wrap();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, '0);
    checks++; if (bus.ifid_pc_plus4 !== 32'h0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap got pc4 %h pc %h want 0/0", bus.ifid_pc_plus4, bus.imem_addr); end
    checks++; if (bus.ifid_instr !== imem(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr got %h want %h", bus.ifid_instr, imem(32'hFFFF_FFFC)); end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom & 32'h000F_FFFF);
  endtask
  task automatic test_reset_mid_stall();
    cycle(1'b1, 1'b0, '0);
    #2;
    do_reset(32'h0);
    cycle(1'b1, 1'b1, 32'h400);
    checks++; if (bus.imem_addr !== 32'h0 || bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL restart_load got %h/%b want 0/0", bus.imem_addr, bus.ifid_valid); end
    cycle(1'b0, 1'b0, '0);
    checks++; if (bus.ifid_instr !== imem(32'h0) || bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL restart_fetch got %h/%b want %h/1", bus.ifid_instr, bus.ifid_valid, imem(32'h0)); end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start_pc = '0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    #12;
    test_reset_and_first_fetch();
    test_stall();
    test_redirect();
    test_redirect_over_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
